microstep_sequencer: RTL and testbench
======================================

MICROSTEP_SEQUENCER -- requirements
Module: microstep_sequencer

Interface
REQ-001 Parameter CW_WIDTH, default 45: control-word width driven to the data path.
REQ-002 Parameter DEPTH, default 16: number of program entries.
REQ-003 Parameter ADDR_W, default 4: entry-index width; the block SHALL require 2**ADDR_W >= DEPTH.
REQ-004 Parameter TIMEOUT, default 64: maximum cycles spent waiting for MFC in one step.
REQ-005 Port CLK, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 Port CLR, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port START, input, 1 bit: begin the program from entry 0; sampled only in IDLE.
REQ-008 Port ABORT, input, 1 bit: terminate the running program.
REQ-009 Port LOOP, input, 1 bit: 1 = restart at entry 0 after the last entry; sampled at each end-of-program.
REQ-010 Port MFC, input, 1 bit: memory-function-complete from the data path.
REQ-011 Port PROG_WE, input, 1 bit: program-entry write enable.
REQ-012 Port PROG_ADDR, input, ADDR_W bits: entry index to write.
REQ-013 Port PROG_DATA, input, CW_WIDTH+2 bits: entry contents; bit CW_WIDTH+1 = LAST, bit CW_WIDTH = WAIT, bits CW_WIDTH-1:0 = control word.
REQ-014 Port CW, output, CW_WIDTH bits: registered control word to the data path.
REQ-015 Port PC, output, ADDR_W bits: index of the entry currently driven on CW.
REQ-016 Port BUSY, output, 1 bit: program running.
REQ-017 Port DONE, output, 1 bit: one-cycle pulse on normal, non-looping completion.
REQ-018 Port ERR, output, 1 bit: sticky MFC-timeout flag.

Function
REQ-019 The FSM SHALL have two states: IDLE and RUN.
REQ-020 In IDLE, CW SHALL be 0 and BUSY SHALL be 0.
REQ-021 PROG_WE=1 in IDLE SHALL write PROG_DATA to entry PROG_ADDR at the clock edge.
REQ-022 PROG_WE SHALL be ignored while BUSY=1, and writes to PROG_ADDR >= DEPTH SHALL be ignored.
REQ-023 START=1 in IDLE (with ABORT=0) SHALL, at the next edge, enter RUN with PC=0, CW=entry[0].CW, BUSY=1 and ERR cleared. Latency is 1 cycle.
REQ-024 In RUN, if the current entry has WAIT=0, or has WAIT=1 with MFC=1, the step SHALL complete at the next edge.
REQ-025 If the current entry has WAIT=1 and MFC=0, the block SHALL hold CW and PC and increment the wait counter.
REQ-026 The wait counter SHALL clear to 0 whenever a step completes or RUN is entered.
REQ-027 On completion of a step that is not the end of the program, PC SHALL become PC+1 and CW SHALL become entry[PC+1].CW. Each WAIT=0 step lasts exactly 1 cycle.
REQ-028 End of program SHALL be an entry with LAST=1, or PC=DEPTH-1 regardless of LAST (implicit end; PC never exceeds DEPTH-1).
REQ-029 At end-of-step on the end of program with LOOP=1, the block SHALL set PC=0 and CW=entry[0].CW, with BUSY held at 1.
REQ-030 At end-of-step on the end of program with LOOP=0, the block SHALL enter IDLE with CW=0 and BUSY=0, and assert DONE=1 for exactly that one cycle.
REQ-031 If the wait counter equals TIMEOUT-1 with MFC=0, the next edge SHALL enter IDLE with CW=0, BUSY=0 and ERR=1; DONE SHALL NOT assert.
REQ-032 ERR SHALL remain 1 until the next accepted START or reset.
REQ-033 MFC=1 in the same cycle the counter reaches TIMEOUT-1 SHALL count as completion, with no error.
REQ-034 ABORT=1 in RUN SHALL enter IDLE at the next edge with CW=0, BUSY=0, DONE=0 and ERR unchanged.
REQ-035 ABORT=1 together with START=1 in IDLE SHALL leave the block in IDLE.
REQ-036 START while in RUN SHALL be ignored.
REQ-037 MFC SHALL be ignored for entries with WAIT=0 and while in IDLE.

Reset
REQ-038 CLR=0 sampled at a rising edge SHALL force IDLE, CW=0, PC=0, BUSY=0, DONE=0, ERR=0 and wait counter=0, including mid-RUN; reset SHALL take priority over all other inputs.
REQ-039 Program-entry contents SHALL NOT be altered by reset.

Verification
REQ-040 Load entries 0..2 with CW=1,2,3 (entry 2 LAST=1, all WAIT=0), pulse START with LOOP=0 -> CW=1,2,3 on consecutive cycles, PC=0,1,2, then CW=0 with DONE=1 for one cycle and BUSY=0.
REQ-041 Entry 1 with WAIT=1; hold MFC=0 for 10 cycles, then MFC=1 -> CW stays at entry[1] for 11 cycles, then advances; ERR=0.
REQ-042 Entry 0 with WAIT=1, MFC held at 0, TIMEOUT=64 -> BUSY falls after 64 cycles in RUN, ERR=1, CW=0; a subsequent START clears ERR.
REQ-043 Three-entry program with LOOP=1 -> CW sequence 1,2,3,1,2,3,... with no DONE; assert ABORT -> CW=0 and BUSY=0 on the next cycle.
REQ-044 No LAST bit set in any of the 16 entries -> PC runs 0..15, then DONE; PROG_WE pulsed mid-run does not change the memory contents.
REQ-045 CLR=0 at PC=5 of a running program -> CW=0, PC=0, BUSY=0 next cycle; a START after CLR returns to 1 replays the unchanged program.

Source files
------------

// File: rtl/microstep_sequencer.sv
// Microprogrammed control-word sequencer: steps through a writable program store,
// optionally stalling on MFC per entry, with loop, abort and MFC-timeout handling.
module microstep_sequencer #(
    parameter int unsigned CW_WIDTH = 45,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                START,
    input  logic                ABORT,
    input  logic                LOOP,
    input  logic                MFC,
    input  logic                PROG_WE,
    input  logic [ADDR_W-1:0]   PROG_ADDR,
    input  logic [CW_WIDTH+1:0] PROG_DATA,
    output logic [CW_WIDTH-1:0] CW,
    output logic [ADDR_W-1:0]   PC,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);

    localparam int unsigned ENTRY_W = CW_WIDTH + 2;
    localparam int unsigned WCNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
        $error("microstep_sequencer: ADDR_W too narrow for DEPTH");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state, state_n;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [WCNT_W-1:0]   wcnt, wcnt_n;
    logic [CW_WIDTH-1:0] cw_n;
    logic [ADDR_W-1:0]   pc_n;
    logic                done_n;
    logic                err_n;
    logic [ENTRY_W-1:0]  cur;
    logic [ENTRY_W-1:0]  nxt;
    logic [ENTRY_W-1:0]  first;
    logic                step_ok;
    logic                at_end;
    logic                wr_en;

    assign cur     = mem[PC];
    assign nxt     = mem[PC + 1'b1];
    assign first   = mem[0];
    assign step_ok = !cur[CW_WIDTH] || MFC;
    // PC never passes DEPTH-1: the last physical entry ends the program even without LAST.
    assign at_end  = cur[CW_WIDTH+1] || (PC == LAST_IDX);
    assign BUSY    = (state == RUN);
    assign wr_en   = CLR && (state == IDLE) && PROG_WE && ({1'b0, PROG_ADDR} < DEPTH_V);

    // Program store has no reset so its contents survive CLR.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[PROG_ADDR] <= PROG_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state <= IDLE;
            CW    <= '0;
            PC    <= '0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            CW    <= cw_n;
            PC    <= pc_n;
            DONE  <= done_n;
            ERR   <= err_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cw_n    = CW;
        pc_n    = PC;
        done_n  = 1'b0;
        err_n   = ERR;
        wcnt_n  = wcnt;
        unique case (state)
            IDLE: begin
                if (START && !ABORT) begin
                    state_n = RUN;
                    pc_n    = '0;
                    cw_n    = first[CW_WIDTH-1:0];
                    err_n   = 1'b0;
                    wcnt_n  = '0;
                end
            end
            RUN: begin
                if (ABORT) begin
                    state_n = IDLE;
                    cw_n    = '0;
                end else if (step_ok) begin
                    wcnt_n = '0;
                    if (at_end) begin
                        if (LOOP) begin
                            pc_n = '0;
                            cw_n = first[CW_WIDTH-1:0];
                        end else begin
                            state_n = IDLE;
                            cw_n    = '0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        pc_n = PC + 1'b1;
                        cw_n = nxt[CW_WIDTH-1:0];
                    end
                end else if (wcnt == WCNT_MAX) begin
                    // MFC arriving on the final allowed cycle is taken by the branch above.
                    state_n = IDLE;
                    cw_n    = '0;
                    err_n   = 1'b1;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cw_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_microstep_sequencer.sv
// Self-checking bench for microstep_sequencer: directed scenarios plus randomized
// traffic, all compared every cycle against a program-level behavioural model.
module tb_microstep_sequencer;

    localparam int CWW    = 45;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int TMO    = 64;
    localparam int DW     = CWW + 2;

    logic            clk = 1'b0;
    logic            clr = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            loop_en = 1'b0;
    logic            mfc = 1'b0;
    logic            prog_we = 1'b0;
    logic [AW-1:0]   prog_addr = '0;
    logic [DW-1:0]   prog_data = '0;
    logic [CWW-1:0]  cw;
    logic [AW-1:0]   pc;
    logic            busy;
    logic            done;
    logic            err;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy = 0;
    bit            m_done = 0;
    bit            m_err  = 0;
    bit            m_pc_known = 0;
    int            m_pc   = 0;
    int            m_wait = 0;

    microstep_sequencer #(
        .CW_WIDTH (CWW),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .TIMEOUT  (TMO)
    ) dut (
        .CLK       (clk),
        .CLR       (clr),
        .START     (start),
        .ABORT     (abort),
        .LOOP      (loop_en),
        .MFC       (mfc),
        .PROG_WE   (prog_we),
        .PROG_ADDR (prog_addr),
        .PROG_DATA (prog_data),
        .CW        (cw),
        .PC        (pc),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs presented for this edge.
    task automatic model_step();
        logic [DW-1:0] e;
        m_done = 0;
        if (!clr) begin
            m_busy = 0; m_pc = 0; m_err = 0; m_wait = 0; m_pc_known = 1;
        end else if (!m_busy) begin
            if (prog_we && int'(prog_addr) < DEPTH) m_mem[prog_addr] = prog_data;
            if (start && !abort) begin
                m_busy = 1; m_pc = 0; m_err = 0; m_wait = 0; m_pc_known = 1;
            end
        end else if (abort) begin
            m_busy = 0; m_pc_known = 0;
        end else begin
            e = m_mem[m_pc];
            if (!e[CWW] || mfc) begin
                m_wait = 0;
                if (e[CWW+1] || m_pc == DEPTH - 1) begin
                    if (loop_en) m_pc = 0;
                    else begin m_busy = 0; m_done = 1; m_pc_known = 0; end
                end else begin
                    m_pc++;
                end
            end else if (m_wait == TMO - 1) begin
                m_busy = 0; m_err = 1; m_pc_known = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic check_all();
        logic [DW-1:0]  e;
        logic [CWW-1:0] exp_cw;
        e = m_mem[m_pc];
        exp_cw = m_busy ? e[CWW-1:0] : '0;
        chk("cw",   64'(cw),   64'(exp_cw));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("err",  64'(err),  64'(m_err));
        if (m_pc_known) chk("pc", 64'(pc), 64'(m_pc));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic load(input int idx, input bit last, input bit wt, input logic [CWW-1:0] w);
        prog_we = 1; prog_addr = AW'(idx); prog_data = {last, wt, w};
        tick();
        prog_we = 0;
    endtask

    task automatic rand_phase(input int cycles, input int mfc_div);
        logic [63:0] r;
        for (int i = 0; i < cycles; i++) begin
            clr     = ($urandom_range(0, 199) != 0);
            start   = ($urandom_range(0, 9) == 0);
            abort   = ($urandom_range(0, 59) == 0);
            loop_en = ($urandom_range(0, 3) == 0);
            mfc     = ($urandom_range(0, mfc_div - 1) == 0);
            prog_we = ($urandom_range(0, 5) == 0) && !start;
            prog_addr = AW'($urandom_range(0, DEPTH - 1));
            r = {$urandom, $urandom};
            prog_data = {($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), r[CWW-1:0]};
            tick();
        end
        clr = 1; start = 0; abort = 0; loop_en = 0; mfc = 0; prog_we = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // reset
        clr = 0;
        tick();
        tick();
        chk("rst_pc", 64'(pc), 64'(0));
        clr = 1;
        for (int i = 0; i < DEPTH; i++) load(i, 0, 0, CWW'(50 + i));

        // three-entry program, no loop
        load(0, 0, 0, CWW'(1));
        load(1, 0, 0, CWW'(2));
        load(2, 1, 0, CWW'(3));
        start = 1; tick(); start = 0;
        chk("p3_cw0", 64'(cw), 64'(1)); chk("p3_pc0", 64'(pc), 64'(0));
        tick();
        chk("p3_cw1", 64'(cw), 64'(2)); chk("p3_pc1", 64'(pc), 64'(1));
        tick();
        chk("p3_cw2", 64'(cw), 64'(3)); chk("p3_pc2", 64'(pc), 64'(2));
        tick();
        chk("p3_end_cw", 64'(cw), 64'(0)); chk("p3_end_done", 64'(done), 64'(1));
        chk("p3_end_busy", 64'(busy), 64'(0));
        tick();
        chk("p3_done_pulse", 64'(done), 64'(0));

        // MFC wait on entry 1: held 11 cycles
        load(1, 0, 1, CWW'(2));
        start = 1; tick(); start = 0; mfc = 0;
        tick();
        n = 0;
        for (int i = 0; i <= 10; i++) begin
            mfc = (i == 10);
            if (cw == CWW'(2)) n++;
            tick();
        end
        mfc = 0;
        chk("wait_hold_cycles", 64'(n), 64'(11));
        chk("wait_adv_cw", 64'(cw), 64'(3));
        chk("wait_err", 64'(err), 64'(0));
        tick();
        load(1, 0, 0, CWW'(2));

        // MFC timeout on entry 0
        load(0, 0, 1, CWW'(1));
        start = 1; tick(); start = 0; mfc = 0;
        n = 1;
        for (int i = 0; i < 200 && busy; i++) begin
            tick();
            if (busy) n++;
        end
        chk("tmo_run_cycles", 64'(n), 64'(TMO));
        chk("tmo_err", 64'(err), 64'(1));
        chk("tmo_cw", 64'(cw), 64'(0));
        tick();
        chk("tmo_err_sticky", 64'(err), 64'(1));
        start = 1; tick(); start = 0;
        chk("tmo_err_clear", 64'(err), 64'(0));
        abort = 1; tick(); abort = 0;
        chk("abort_busy", 64'(busy), 64'(0));
        load(0, 0, 0, CWW'(1));

        // START with ABORT in idle stays idle
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        chk("start_abort_busy", 64'(busy), 64'(0));

        // looping program then abort
        loop_en = 1;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 9; i++) begin
            chk("loop_cw", 64'(cw), 64'((i % 3) + 1));
            chk("loop_nodone", 64'(done), 64'(0));
            tick();
        end
        abort = 1; tick(); abort = 0; loop_en = 0;
        chk("loop_abort_cw", 64'(cw), 64'(0));
        chk("loop_abort_busy", 64'(busy), 64'(0));

        // full 16 entries, no LAST, write attempted mid-run
        for (int i = 0; i < DEPTH; i++) load(i, 0, 0, CWW'(100 + i));
        start = 1; tick(); start = 0;
        for (int k = 0; k < DEPTH; k++) begin
            chk("full_pc", 64'(pc), 64'(k));
            chk("full_cw", 64'(cw), 64'(100 + k));
            prog_we = (k == 5 || k == 6); prog_addr = AW'(3); prog_data = {1'b1, 1'b0, CWW'('h1234)};
            tick();
        end
        prog_we = 0;
        chk("full_done", 64'(done), 64'(1));

        // reset mid-run at PC=5, then replay
        start = 1; tick(); start = 0;
        for (int k = 0; k < 5; k++) tick();
        chk("rst_mid_pc_before", 64'(pc), 64'(5));
        clr = 0; tick(); clr = 1;
        chk("rst_mid_cw", 64'(cw), 64'(0));
        chk("rst_mid_pc", 64'(pc), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        start = 1; tick(); start = 0;
        for (int k = 0; k < DEPTH; k++) begin
            chk("replay_cw", 64'(cw), 64'(100 + k));
            tick();
        end
        chk("replay_done", 64'(done), 64'(1));

        // randomized traffic against the model
        rand_phase(1500, 2);
        rand_phase(1500, 30);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
